// File: rtl/branch_issue_queue.sv
// Circular FIFO between the B-format decoder and the branch unit, with decoder back-pressure.
// Define BRANCH_ISSUE_QUEUE_FLUSH_EN to make flush_i discard all pending entries.
module branch_issue_queue #(
   parameter int unsigned addressWidth            = 64,
   parameter int unsigned opcodeSize              = 6,
   parameter int unsigned instructionCounterWidth = 64,
   parameter int unsigned instMinIdWidth          = 7,
   parameter int unsigned PidSize                 = 20,
   parameter int unsigned TidSize                 = 16,
   parameter int unsigned bodySize                = 26,
   parameter int unsigned queueDepth              = 4
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               enable_i,
   input  logic [opcodeSize-1:0]              instructionOpcode_i,
   input  logic [addressWidth-1:0]            instructionAddress_i,
   input  logic [instructionCounterWidth:0]   instMajId_i,
   input  logic [instMinIdWidth-1:0]          instMinId_i,
   input  logic                               is64Bit_i,
   input  logic [PidSize-1:0]                 instPid_i,
   input  logic [TidSize-1:0]                 instTid_i,
   input  logic [bodySize-1:0]                instructionBody_i,
   input  logic                               flush_i,
   input  logic                               deq_i,
   output logic                               stall_o,
   output logic                               valid_o,
   output logic [opcodeSize-1:0]              instructionOpcode_o,
   output logic [addressWidth-1:0]            instructionAddress_o,
   output logic [instructionCounterWidth:0]   instMajId_o,
   output logic [instMinIdWidth-1:0]          instMinId_o,
   output logic                               is64Bit_o,
   output logic [PidSize-1:0]                 instPid_o,
   output logic [TidSize-1:0]                 instTid_o,
   output logic [bodySize-1:0]                instructionBody_o,
   output logic [$clog2(queueDepth):0]        count_o,
   output logic                               overflow_o
);

   localparam int unsigned PtrW   = $clog2(queueDepth);
   localparam int unsigned CntW   = PtrW + 1;
   localparam int unsigned EntryW = opcodeSize + addressWidth + instructionCounterWidth + 1 +
                                    instMinIdWidth + 1 + PidSize + TidSize + bodySize;

   logic [EntryW-1:0] r_array [queueDepth];
   logic [PtrW-1:0]   r_rd_ptr;
   logic [PtrW-1:0]   r_wr_ptr;
   logic [CntW-1:0]   r_count;
   logic              r_overflow;

   logic              w_flush;
   logic              w_full;
   logic              w_deq;
   logic              w_enq;
   logic              w_drop;
   logic [EntryW-1:0] w_wr_entry;
   logic [EntryW-1:0] w_rd_entry;

`ifdef BRANCH_ISSUE_QUEUE_FLUSH_EN
   assign w_flush = flush_i;
`else
   // Port kept for a stable instantiation; masked so it never affects state.
   assign w_flush = flush_i & 1'b0;
`endif

   assign w_full = (r_count == CntW'(queueDepth));
   assign w_deq  = deq_i && (r_count != '0);
   // A deq in the same cycle frees the slot, so a write while full is still accepted.
   assign w_enq  = enable_i && (!w_full || w_deq);
   assign w_drop = enable_i && w_full && !w_deq;

   assign w_wr_entry = {instructionOpcode_i, instructionAddress_i, instMajId_i, instMinId_i,
                        is64Bit_i, instPid_i, instTid_i, instructionBody_i};
   assign w_rd_entry = r_array[r_rd_ptr];

   assign {instructionOpcode_o, instructionAddress_o, instMajId_o, instMinId_o,
           is64Bit_o, instPid_o, instTid_o, instructionBody_o} = w_rd_entry;

   assign valid_o    = (r_count != '0);
   assign stall_o    = (r_count >= CntW'(queueDepth - 1));
   assign count_o    = r_count;
   assign overflow_o = r_overflow;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + PtrW'(1);
         if (w_deq) r_rd_ptr <= r_rd_ptr + PtrW'(1);
         r_count <= r_count + CntW'(w_enq) - CntW'(w_deq);
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   // Storage has no reset; stale contents are hidden by count.
   always_ff @(posedge clock_i) begin
      if (!reset_i && !w_flush && w_enq) r_array[r_wr_ptr] <= w_wr_entry;
   end

endmodule
